// File: rtl/fxp_requant_if.sv
// Streaming handshake bundle for the fixed-point requantizer.
// Input side carries per-beat shift and rounding mode alongside the samples.
interface fxp_requant_if #(
  parameter int IN_WIDTH    = 40,
  parameter int OUT_WIDTH   = 20,
  parameter int N_CH        = 2,
  parameter int SHIFT_WIDTH = 6
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N_CH*IN_WIDTH-1:0]  in_dat;
  logic [SHIFT_WIDTH-1:0]    in_shift;
  logic [1:0]                in_mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_CH*OUT_WIDTH-1:0] out_dat;
  logic [N_CH-1:0]           out_sat;

  // Upstream/downstream driver side.
  modport master (
    output in_valid, in_dat, in_shift, in_mode, out_ready,
    input  in_ready, out_valid, out_dat, out_sat
  );

  // Requantizer side.
  modport slave (
    input  in_valid, in_dat, in_shift, in_mode, out_ready,
    output in_ready, out_valid, out_dat, out_sat
  );
endinterface

// File: rtl/fxp_requant.sv
// Two-stage multi-channel requantizer: S1 shifts right with a selectable
// rounding mode, S2 saturates to OUT_WIDTH and drives the outputs.
// Each beat carries its own shift/mode; valid/ready on both sides.
module fxp_requant #(
  parameter int IN_WIDTH    = 40,
  parameter int OUT_WIDTH   = 20,
  parameter int N_CH        = 2,
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fxp_requant_if.slave         bus,
  output logic [CNT_WIDTH-1:0] sat_cnt,
  input  logic                 sat_cnt_clr
);

  // One extra bit so adding the half-LSB, or negating the most negative
  // input, can never overflow.
  localparam int RW = IN_WIDTH + 1;
  typedef logic signed [RW-1:0] wide_t;

  localparam wide_t       ONE     = wide_t'(1);
  localparam logic [31:0] MAX_SH  = 32'(IN_WIDTH - 1);
  localparam wide_t       SAT_MAX = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam wide_t       SAT_MIN = {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Rounding modes: 0 half-even, 1 half-up, 2 truncate, 3 half-away-from-zero.
  function automatic wide_t round_shift(input logic signed [IN_WIDTH-1:0] x,
                                        input logic [SHIFT_WIDTH-1:0]     n,
                                        input logic [1:0]                 mode);
    wide_t xe, h, mask, sum, mag, q;
    xe   = {x[IN_WIDTH-1], x};
    h    = ONE << (n - 1'b1);
    mask = (ONE << n) - ONE;
    sum  = xe + h;
    mag  = -xe;
    q    = xe;
    if (n != '0) begin
      case (mode)
        2'd0: begin
          q = sum >>> n;
          // Exact tie that rounded up to an odd value goes back to even.
          if (((xe & mask) == h) && q[0]) q = q - ONE;
        end
        2'd1: q = sum >>> n;
        2'd2: q = xe >>> n;
        default: begin
          if (xe[RW-1]) q = -((mag + h) >>> n);
          else          q = sum >>> n;
        end
      endcase
    end
    return q;
  endfunction

  logic                           en1, en2;
  logic [SHIFT_WIDTH-1:0]         shift_eff;
  logic                           s1_valid_q, s1_valid_d;
  logic [N_CH-1:0][RW-1:0]        s1_res_q, s1_res_d;
  logic                           s2_valid_q, s2_valid_d;
  logic [N_CH-1:0][OUT_WIDTH-1:0] s2_dat_q, s2_dat_d;
  logic [N_CH-1:0]                s2_sat_q, s2_sat_d;
  logic [CNT_WIDTH-1:0]           sat_cnt_q, sat_cnt_d;
  wide_t                          sat_r;

  assign en2           = !s2_valid_q || bus.out_ready;
  assign en1           = !s1_valid_q || en2;
  assign bus.in_ready  = en1;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_dat   = s2_dat_q;
  assign bus.out_sat   = s2_sat_q;
  assign sat_cnt       = sat_cnt_q;

  // Shifts beyond the word width behave as the widest meaningful shift.
  assign shift_eff = (32'(bus.in_shift) > MAX_SH) ? MAX_SH[SHIFT_WIDTH-1:0] : bus.in_shift;

  // S1 next state: capture and round a beat whenever the stage can advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_res_d   = s1_res_q;
    if (en1) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        for (int k = 0; k < N_CH; k++) begin
          s1_res_d[k] = round_shift(bus.in_dat[k*IN_WIDTH +: IN_WIDTH], shift_eff, bus.in_mode);
        end
      end
    end
  end

  // S2 next state: clamp each channel to the output range and flag clamps.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_dat_d   = s2_dat_q;
    s2_sat_d   = s2_sat_q;
    sat_r      = '0;
    if (en2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int k = 0; k < N_CH; k++) begin
          sat_r = $signed(s1_res_q[k]);
          if (sat_r > SAT_MAX) begin
            s2_dat_d[k] = SAT_MAX[OUT_WIDTH-1:0];
            s2_sat_d[k] = 1'b1;
          end else if (sat_r < SAT_MIN) begin
            s2_dat_d[k] = SAT_MIN[OUT_WIDTH-1:0];
            s2_sat_d[k] = 1'b1;
          end else begin
            s2_dat_d[k] = sat_r[OUT_WIDTH-1:0];
            s2_sat_d[k] = 1'b0;
          end
        end
      end
    end
  end

  // Saturation counter: one count per transferred beat, sticky at full scale,
  // clear takes priority over a coincident increment.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_cnt_clr) begin
      sat_cnt_d = '0;
    end else if (s2_valid_q && bus.out_ready && (|s2_sat_q) && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  // S1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_res_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_res_q   <= s1_res_d;
    end
  end

  // S2 registers, which are the block outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_dat_q   <= '0;
      s2_sat_q   <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_dat_q   <= s2_dat_d;
      s2_sat_q   <= s2_sat_d;
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

endmodule

// File: tb/tb_fxp_requant.sv
// Scoreboard bench for fxp_requant: expected beats are queued at input
// transfer from an independent integer model and checked at output transfer.
`timescale 1ns/1ps
module tb_fxp_requant;
  localparam int IW = 40;
  localparam int OW = 20;
  localparam int NC = 2;
  localparam int SW = 6;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sat_cnt_clr;
  logic [CW-1:0] sat_cnt;

  always #5 clk = ~clk;

  fxp_requant_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .N_CH(NC), .SHIFT_WIDTH(SW)) bus ();

  fxp_requant #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .N_CH(NC), .SHIFT_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sat_cnt     (sat_cnt),
    .sat_cnt_clr (sat_cnt_clr)
  );

  int             n_tests = 0;
  int             n_fail  = 0;
  longint         cyc     = 0;
  longint         in_cyc_last;
  logic           rnd_on;
  logic [NC*OW-1:0] sb_dat[$];
  logic [NC-1:0]    sb_sat[$];
  longint           pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference: floor quotient plus remainder inspection.
  function automatic void model(input longint x, input int sh, input int mode,
                                output logic [OW-1:0] d, output logic s);
    int n;
    longint q, rem, h, r, mx, mn;
    mx = (longint'(1) <<< (OW - 1)) - 1;
    mn = -(longint'(1) <<< (OW - 1));
    n  = (sh > IW - 1) ? IW - 1 : sh;
    if (n == 0) begin
      r = x;
    end else begin
      q   = x >>> n;
      rem = x - (q <<< n);
      h   = longint'(1) <<< (n - 1);
      case (mode)
        0:       r = (rem > h) ? q + 1 : ((rem == h) ? q + (q & 1) : q);
        1:       r = (rem >= h) ? q + 1 : q;
        2:       r = q;
        default: r = ((rem > h) || (rem == h && x >= 0)) ? q + 1 : q;
      endcase
    end
    if (r > mx)      begin d = mx[OW-1:0]; s = 1'b1; end
    else if (r < mn) begin d = mn[OW-1:0]; s = 1'b1; end
    else             begin d = r[OW-1:0];  s = 1'b0; end
  endfunction

  task automatic monitor();
    logic [NC*OW-1:0] ed;
    logic [NC-1:0]    es;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        n_tests++;
        if (sb_dat.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: out_dat=%h out_sat=%b, no beat expected", bus.out_dat, bus.out_sat);
        end else begin
          ed = sb_dat.pop_front();
          es = sb_sat.pop_front();
          pop_cyc.push_back(cyc);
          if (bus.out_dat !== ed || bus.out_sat !== es) begin
            n_fail++;
            $display("FAIL sb_beat: out_dat=%h out_sat=%b expected %h %b", bus.out_dat, bus.out_sat, ed, es);
          end
        end
      end
    end
  endtask

  task automatic rand_ready();
    while (rnd_on) begin
      @(posedge clk); #1;
      if (rnd_on) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Called at posedge+1; leaves in_valid high, returns at posedge+1 after transfer.
  task automatic send_beat(input longint x0, input longint x1, input int sh, input int mode);
    logic [OW-1:0] d0, d1;
    logic          s0, s1;
    int            waitc;
    model(x0, sh, mode, d0, s0);
    model(x1, sh, mode, d1, s1);
    bus.in_valid = 1'b1;
    bus.in_dat   = {x1[IW-1:0], x0[IW-1:0]};
    bus.in_shift = SW'(sh);
    bus.in_mode  = 2'(mode);
    waitc = 0;
    @(negedge clk);
    while (!bus.in_ready && waitc < 1000) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready=%b expected 1 within 1000 cycles", bus.in_ready);
    end else begin
      sb_dat.push_back({d1, d0});
      sb_sat.push_back({s1, s0});
      in_cyc_last = cyc;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int waitc = 0;
    while (sb_dat.size() != 0 && waitc < 1000) begin
      @(posedge clk); #1;
      waitc++;
    end
    n_tests++;
    if (sb_dat.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats outstanding, expected 0", sb_dat.size());
      sb_dat.delete(); sb_sat.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    sat_cnt_clr = 1'b1;
    @(posedge clk); #1;
    sat_cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_dat !== '0 || bus.out_sat !== '0 || sat_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%b dat=%h sat=%b cnt=%0d expected 0 0 0 0",
               bus.out_valid, bus.out_dat, bus.out_sat, sat_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_round_even();
    bus.out_ready = 1'b1;
    send_beat(5, 7, 1, 0);
    send_beat(-5, -7, 1, 0);
    send_beat(6, -6, 2, 0);
    idle();
    drain();
  endtask

  task automatic test_modes();
    bus.out_ready = 1'b1;
    for (int m = 1; m < 4; m++) send_beat(5, -5, 1, m);
    for (int m = 0; m < 4; m++) send_beat(-9, 9, 0, m);
    send_beat(-(longint'(1) <<< (IW - 1)), (longint'(1) <<< (IW - 1)) - 1, 63, 3);
    send_beat(-(longint'(1) <<< (IW - 1)), (longint'(1) <<< (IW - 1)) - 1, 45, 1);
    idle();
    drain();
  endtask

  task automatic test_latency();
    bus.out_ready = 1'b1;
    send_beat(100, -100, 2, 1);
    idle();
    drain();
    n_tests++;
    if (pop_cyc[pop_cyc.size() - 1] - in_cyc_last != 2) begin
      n_fail++;
      $display("FAIL latency: %0d cycles expected 2", pop_cyc[pop_cyc.size() - 1] - in_cyc_last);
    end
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    pulse_clr();
    n_tests++;
    if (sat_cnt !== '0) begin
      n_fail++;
      $display("FAIL sat_clear: sat_cnt=%0d expected 0", sat_cnt);
    end
    send_beat(524288, 3, 0, 0);
    send_beat(-3, -524289, 0, 0);
    idle();
    drain();
    n_tests++;
    if (sat_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL sat_one_ch: sat_cnt=%0d expected 2", sat_cnt);
    end
    send_beat(524288, -524289, 0, 0);
    send_beat(524287, -524288, 0, 0);
    idle();
    drain();
    n_tests++;
    if (sat_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL sat_both_ch: sat_cnt=%0d expected 3", sat_cnt);
    end
  endtask

  task automatic test_backpressure();
    int     k, acc, base, waitc;
    longint bx;
    bus.out_ready = 1'b0;
    acc = 0; k = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bx = 1000 * (k + 1);
      bus.in_dat = {IW'(-bx), IW'(bx)};
      bus.in_shift = '0;
      bus.in_mode  = 2'd2;
      @(negedge clk);
      if (bus.out_valid && sb_dat.size() != 0) begin
        n_tests++;
        if (bus.out_dat !== sb_dat[0]) begin
          n_fail++;
          $display("FAIL bp_stable: out_dat=%h expected %h", bus.out_dat, sb_dat[0]);
        end
      end
      if (bus.in_ready) begin
        sb_dat.push_back({OW'(-bx), OW'(bx)});
        sb_sat.push_back(2'b00);
        acc++; k++;
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (acc != 2 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: accepted=%0d in_ready=%b expected 2 0", acc, bus.in_ready);
    end
    base = pop_cyc.size();
    bus.out_ready = 1'b1;
    waitc = 0;
    while (k < 6 && waitc < 100) begin
      bx = 1000 * (k + 1);
      bus.in_dat = {IW'(-bx), IW'(bx)};
      @(negedge clk);
      if (bus.in_ready) begin
        sb_dat.push_back({OW'(-bx), OW'(bx)});
        sb_sat.push_back(2'b00);
        k++;
      end
      @(posedge clk); #1;
      waitc++;
    end
    idle();
    drain();
    n_tests++;
    if (pop_cyc.size() - base != 6 || pop_cyc[pop_cyc.size() - 1] - pop_cyc[base] != 5) begin
      n_fail++;
      $display("FAIL bp_stream: beats=%0d span=%0d expected 6 5", pop_cyc.size() - base,
               pop_cyc[pop_cyc.size() - 1] - pop_cyc[base]);
    end
  endtask

  task automatic test_sat_cnt_limit();
    int waitc;
    bus.out_ready = 1'b1;
    pulse_clr();
    for (int i = 0; i < 65534; i++) send_beat(1 <<< 25, 5, 0, 2);
    idle();
    drain();
    n_tests++;
    if (sat_cnt !== 16'd65534) begin
      n_fail++;
      $display("FAIL cnt_preload: sat_cnt=%0d expected 65534", sat_cnt);
    end
    for (int i = 0; i < 3; i++) send_beat(-(1 <<< 30), 0, 0, 1);
    idle();
    drain();
    n_tests++;
    if (sat_cnt !== 16'd65535) begin
      n_fail++;
      $display("FAIL cnt_hold: sat_cnt=%0d expected 65535", sat_cnt);
    end
    bus.out_ready = 1'b0;
    send_beat(1 <<< 24, 1 <<< 24, 0, 0);
    idle();
    waitc = 0;
    while (!bus.out_valid && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    sat_cnt_clr   = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    sat_cnt_clr = 1'b0;
    n_tests++;
    if (sat_cnt !== '0 || sb_dat.size() != 0) begin
      n_fail++;
      $display("FAIL cnt_clr_wins: sat_cnt=%0d pending=%0d expected 0 0", sat_cnt, sb_dat.size());
    end
  endtask

  task automatic test_reset_inflight();
    int base;
    bus.out_ready = 1'b0;
    send_beat(11, 22, 0, 0);
    send_beat(33, 44, 0, 0);
    idle();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_dat !== '0 || bus.out_sat !== '0) begin
      n_fail++;
      $display("FAIL rst_flight: v=%b dat=%h sat=%b expected 0 0 0", bus.out_valid, bus.out_dat, bus.out_sat);
    end
    sb_dat.delete();
    sb_sat.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    base = pop_cyc.size();
    send_beat(-77, 300, 2, 3);
    idle();
    drain();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (pop_cyc.size() - base != 1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_resume: beats=%0d out_valid=%b expected 1 0", pop_cyc.size() - base, bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [63:0] rr;
    longint      x0, x1;
    rnd_on = 1'b1;
    fork rand_ready(); join_none
    for (int i = 0; i < 1000; i++) begin
      rr = {$urandom, $urandom};
      x0 = longint'($signed(rr[IW-1:0])) >>> $urandom_range(0, IW - 1);
      rr = {$urandom, $urandom};
      x1 = longint'($signed(rr[IW-1:0])) >>> $urandom_range(0, IW - 1);
      send_beat(x0, x1, int'($urandom_range(0, 63)), (i < 500) ? 0 : int'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) begin
        idle();
        @(posedge clk); #1;
      end
    end
    idle();
    rnd_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_dat    = '0;
    bus.in_shift  = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;
    sat_cnt_clr   = 1'b0;
    rnd_on        = 1'b0;
    in_cyc_last   = 0;
    fork monitor(); join_none
    test_reset();
    test_round_even();
    test_modes();
    test_latency();
    test_saturation();
    test_backpressure();
    test_reset_inflight();
    test_random();
    test_sat_cnt_limit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
